serial_subtractor: RTL and testbench

Bit-serial N-bit subtractor that computes a − b LSB-first, one bit per clock, using a single 1-bit full-subtractor cell and a borrow flip-flop. It is the arithmetic inverse of the team's 1-bit full-adder cell. It is used wherever area matters more than latency, for example in small datapath counters and comparators in the basic-programs set. A start/busy/done handshake accepts one operand pair at a time and holds the result until the next completes.

---
 rtl/serial_sub_pkg.sv | 18 +
 rtl/full_subtractor.sv | 21 ++
 rtl/serial_subtractor.sv | 116 +++++++++++
 tb/tb_serial_subtractor.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
//   state_t    : controller states (IDLE, RUN, DONE)
//   cnt_width  : bit-counter width for a given operand width (never below 1)
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter spans 0..width-1, so $clog2(width) bits are enough.
  // A one-bit floor keeps the declaration legal for the smallest width.
  function automatic int cnt_width(input int width);
    return ($clog2(width) > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full-subtractor cell: d = a - b - bin, with borrow-out.
// This is the arithmetic inverse of the 1-bit full-adder cell.
//   a    : minuend bit
//   b    : subtrahend bit
//   bin  : borrow in
//   d    : difference bit
//   bout : borrow out
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  // Borrow when b exceeds a outright, or when they are equal and a borrow
  // is already pending.
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: diff = (a - b) mod 2^WIDTH, LSB first,
// one bit per clock through a single full-subtractor cell.
//   clk    : rising-edge clock
//   rst    : synchronous, active-high reset
//   start  : request a new operation (honoured only while busy = 0)
//   a, b   : minuend / subtrahend, captured when start is accepted
//   busy   : high while bits are being processed (WIDTH cycles)
//   done   : one-cycle pulse when diff/borrow have just been updated
//   diff   : last completed result, held until the next one completes
//   borrow : last completed borrow-out (1 iff a < b, unsigned)
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  import serial_sub_pkg::*;

  localparam int                CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t             state;
  logic [CNT_W-1:0]   count;
  logic [WIDTH-1:0]   sa;
  logic [WIDTH-1:0]   sb;
  logic [WIDTH-1:0]   sr;
  logic [WIDTH-1:0]   sr_next;
  logic               bflop;
  logic               cell_d;
  logic               cell_bout;

  full_subtractor u_cell (
    .a    (sa[0]),
    .b    (sb[0]),
    .bin  (bflop),
    .d    (cell_d),
    .bout (cell_bout)
  );

  // Working register after this cycle's bit is shifted into the MSB. After
  // WIDTH shifts the first (LSB) result bit has arrived at bit 0.
  always_comb begin
    // NOTE: assign a full default before the partial override so no path
    // leaves sr_next unassigned; otherwise a latch would be inferred.
    sr_next            = sr >> 1;
    sr_next[WIDTH-1]   = cell_d;
  end

  // NOTE: every register below uses non-blocking assignment so all state
  // updates see the pre-edge values, matching the hardware flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      count  <= '0;
      sa     <= '0;
      sb     <= '0;
      sr     <= '0;
      bflop  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
    end else begin
      case (state)
        // DONE accepts start exactly like IDLE, which gives back-to-back
        // operation with start held high.
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            sa    <= a;
            sb    <= b;
            sr    <= '0;
            bflop <= 1'b0;
            count <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end

        // start is not examined here, so a request while busy has no effect.
        RUN: begin
          sa    <= sa >> 1;
          sb    <= sb >> 1;
          sr    <= sr_next;
          bflop <= cell_bout;
          count <= count + 1'b1;
          if (count == LAST_BIT) begin
            // Outputs are written only here, so partial results never show.
            diff   <= sr_next;
            borrow <= cell_bout;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= DONE;
          end
        end

        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: a WIDTH=8 instance for the
// directed, table and random tests, and a WIDTH=4 instance swept over all
// operand pairs. Expected results come from plain modular arithmetic.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst;
  logic       start8, start4;
  logic [7:0] a8, b8, diff8;
  logic       busy8, done8, borrow8;
  logic [3:0] a4, b4, diff4;
  logic       busy4, done4, borrow4;

  int n_checks = 0;
  int n_fail   = 0;
  int overlap  = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow(borrow8)
  );

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .diff(diff4), .borrow(borrow4)
  );

  always @(negedge clk) begin
    if ((busy8 && done8) || (busy4 && done4)) overlap++;
  end

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] diff;
    logic       borrow;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Runs one operation on the 8-bit instance from an idle state. lat is the
  // cycle (counting from the accept edge) in which done was seen, 0 on timeout.
  task automatic run_op8(input logic [7:0] a, input logic [7:0] b,
                         output logic [7:0] d, output logic br,
                         output int lat, output int nbusy);
    start8 = 1'b1; a8 = a; b8 = b;
    @(negedge clk);
    start8 = 1'b0; a8 = ~a; b8 = ~b;
    lat = 0; nbusy = 0; d = 'x; br = 1'bx;
    for (int c = 1; c <= 40; c++) begin
      if (busy8) nbusy++;
      if (done8) begin
        lat = c; d = diff8; br = borrow8;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic run_op4(input logic [3:0] a, input logic [3:0] b,
                         output logic [3:0] d, output logic br, output int lat);
    start4 = 1'b1; a4 = a; b4 = b;
    @(negedge clk);
    start4 = 1'b0; a4 = ~a; b4 = ~b;
    lat = 0; d = 'x; br = 1'bx;
    for (int c = 1; c <= 20; c++) begin
      if (done4) begin
        lat = c; d = diff4; br = borrow4;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] d;
    logic       br;
    logic [3:0] d4;
    logic       br4;
    int         lat, nbusy, ndone, first_done, second_done, hold_bad;
    logic [7:0] d1, d2;
    logic       br1, br2;
    int         ra, rb;

    vecs[0] = '{8'd100, 8'd37,  8'd63,  1'b0};
    vecs[1] = '{8'd5,   8'd10,  8'd251, 1'b1};
    vecs[2] = '{8'd0,   8'd0,   8'd0,   1'b0};
    vecs[3] = '{8'd255, 8'd255, 8'd0,   1'b0};
    vecs[4] = '{8'd200, 8'd1,   8'd199, 1'b0};
    vecs[5] = '{8'd0,   8'd255, 8'd1,   1'b1};
    vecs[6] = '{8'd255, 8'd0,   8'd255, 1'b0};
    vecs[7] = '{8'd128, 8'd129, 8'd255, 1'b1};

    rst = 1'b1; start8 = 1'b0; start4 = 1'b0;
    a8 = '0; b8 = '0; a4 = '0; b4 = '0;
    repeat (3) @(negedge clk);
    check("reset busy",   busy8,   0);
    check("reset done",   done8,   0);
    check("reset diff",   diff8,   0);
    check("reset borrow", borrow8, 0);
    rst = 1'b0;

    // Table of directed operand pairs, including the wrap and equal cases.
    for (int i = 0; i < 8; i++) begin
      run_op8(vecs[i].a, vecs[i].b, d, br, lat, nbusy);
      check($sformatf("vec%0d diff", i),    d,     vecs[i].diff);
      check($sformatf("vec%0d borrow", i),  br,    vecs[i].borrow);
      check($sformatf("vec%0d latency", i), lat,   9);
      check($sformatf("vec%0d busy", i),    nbusy, 8);
    end

    // Random operands against modular arithmetic.
    for (int i = 0; i < 24; i++) begin
      ra = int'($urandom_range(0, 255));
      rb = int'($urandom_range(0, 255));
      run_op8(8'(ra), 8'(rb), d, br, lat, nbusy);
      check($sformatf("rand %0d-%0d diff", ra, rb),   d,  (ra - rb) & 255);
      check($sformatf("rand %0d-%0d borrow", ra, rb), br, (ra < rb) ? 1 : 0);
    end

    // start pulsed during RUN cycle 3 with other operands must be ignored.
    start8 = 1'b1; a8 = 8'd100; b8 = 8'd37;
    @(negedge clk);
    start8 = 1'b0;
    ndone = 0; lat = 0; d = 'x; br = 1'bx;
    for (int c = 1; c <= 15; c++) begin
      if (done8) begin ndone++; lat = c; d = diff8; br = borrow8; end
      start8 = (c == 3);
      if (c == 3) begin a8 = 8'd1; b8 = 8'd1; end
      @(negedge clk);
    end
    start8 = 1'b0;
    check("ignore done count", ndone, 1);
    check("ignore latency",    lat,   9);
    check("ignore diff",       d,     63);
    check("ignore borrow",     br,    0);

    // Reset during RUN aborts: outputs cleared, no done afterwards.
    start8 = 1'b1; a8 = 8'd100; b8 = 8'd37;
    @(negedge clk);
    start8 = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      if (c == 4) rst = 1'b1;
      @(negedge clk);
    end
    rst = 1'b0;
    check("abort busy",   busy8,   0);
    check("abort diff",   diff8,   0);
    check("abort borrow", borrow8, 0);
    ndone = 0;
    for (int c = 0; c < 12; c++) begin
      if (done8) ndone++;
      @(negedge clk);
    end
    check("abort no done", ndone, 0);
    run_op8(8'd200, 8'd1, d, br, lat, nbusy);
    check("after abort diff",   d,  199);
    check("after abort borrow", br, 0);

    // start held high: 10-3 then 3-10 back to back, operands changed mid-run.
    start8 = 1'b1; a8 = 8'd10; b8 = 8'd3;
    @(negedge clk);
    a8 = 8'd3; b8 = 8'd10;
    ndone = 0; first_done = 0; second_done = 0; hold_bad = 0;
    d1 = 'x; d2 = 'x; br1 = 1'bx; br2 = 1'bx;
    for (int c = 1; c <= 20; c++) begin
      if (done8) begin
        ndone++;
        if (ndone == 1) begin first_done = c;  d1 = diff8; br1 = borrow8; end
        if (ndone == 2) begin second_done = c; d2 = diff8; br2 = borrow8; end
      end else if (ndone == 1 && diff8 !== 8'd7) begin
        hold_bad++;
      end
      if (ndone >= 2) start8 = 1'b0;
      @(negedge clk);
    end
    start8 = 1'b0;
    check("b2b done count",   ndone,                     2);
    check("b2b first cycle",  first_done,                9);
    check("b2b gap",          second_done - first_done,  9);
    check("b2b first diff",   d1,                        7);
    check("b2b first borrow", br1,                       0);
    check("b2b hold",         hold_bad,                  0);
    check("b2b second diff",  d2,                        249);
    check("b2b second borrow", br2,                      1);

    // WIDTH=4 exhaustive sweep.
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        run_op4(4'(ia), 4'(ib), d4, br4, lat);
        check($sformatf("w4 %0d-%0d diff", ia, ib),   d4,  (ia - ib) & 15);
        check($sformatf("w4 %0d-%0d borrow", ia, ib), br4, (ia < ib) ? 1 : 0);
        if (ia == ib) check($sformatf("w4 %0d latency", ia), lat, 5);
      end
    end

    check("busy/done overlap", overlap, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
